mat_ops_engine: RTL and testbench

//  Parametrised matrix engine: transpose, add, scalar-multiply, multiply on runtime-sized matrices up to MAX_DIM x MAX_DIM.

---
 rtl/mat_ops_pkg.sv | 28 ++
 rtl/mat_mac.sv | 47 ++++
 rtl/mat_ops_engine.sv | 352 +++++++++++++++++++++++++++++++++++
 tb/tb_mat_ops_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_ops_pkg.sv
// mat_ops_pkg: shared encodings for the matrix engine.
//   op_e    : op_sel encodings (values 4..7 are illegal)
//   state_e : engine FSM states
//   ERR_*   : err_code values
package mat_ops_pkg;

  typedef enum logic [2:0] {
    OP_TRANSPOSE = 3'b000,
    OP_ADD       = 3'b001,
    OP_SCALAR    = 3'b010,
    OP_MUL       = 3'b011
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LOAD_A, S_LOAD_B, S_COMPUTE, S_OUTPUT, S_DONE, S_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_DIM      = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
  localparam logic [1:0] ERR_OP       = 2'd3;

  // Ops that stream a second operand B after A.
  function automatic logic op_needs_b(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/mat_mac.sv
// mat_mac: single multiply-accumulate lane with narrowing to DW bits.
//   acc <= (clr ? 0 : acc) + mul_a*mul_b + add_c   when en
//   res : accumulator narrowed to DW bits (wrap, or clamp if MATOPS_SAT_EN)
//   ovf : accumulator exceeds 2^DW-1
// Ports: clk, rst_n (async low), clr, en, mul_a, mul_b, add_c, res, ovf.
// Config macro: MATOPS_SAT_EN selects saturating narrowing.
module mat_mac
  import mat_ops_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ACC_W = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] mul_a,
  input  logic [DW-1:0] mul_b,
  input  logic [DW-1:0] add_c,
  output logic [DW-1:0] res,
  output logic          ovf
);

  localparam logic [ACC_W-1:0] MAXV = {{(ACC_W-DW){1'b0}}, {DW{1'b1}}};

  logic [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (en)
      acc_d = (clr ? '0 : acc_q) + ACC_W'(mul_a) * ACC_W'(mul_b) + ACC_W'(add_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign ovf = (acc_q > MAXV);

`ifdef MATOPS_SAT_EN
  assign res = ovf ? {DW{1'b1}} : acc_q[DW-1:0];
`else
  assign res = acc_q[DW-1:0];
`endif

endmodule

// File: rtl/mat_ops_engine.sv
// mat_ops_engine: runtime-sized matrix transpose / add / scalar-mul / multiply.
// Operands stream in over in_valid/in_ready (A row-major, then B when needed),
// results stream out over out_valid/out_ready with out_last on the final one.
// Ports:
//   clk, rst_n (async low)
//   start, op_sel, a_rows, a_cols, b_rows, b_cols, scalar_k : command, sampled in IDLE
//   in_valid, in_ready, in_data     : operand stream
//   out_valid, out_ready, out_data, out_last : result stream
//   busy, done, error, err_code, ovf : status
// Config macro: MATOPS_SAT_EN (clamp results to 2^DW-1 instead of wrapping).
// Buffers use a fixed row stride of MAX_DIM so row/col counters index directly.
module mat_ops_engine
  import mat_ops_pkg::*;
#(
  parameter  int DW      = 8,
  parameter  int MAX_DIM = 5,
  localparam int DIM_W   = $clog2(MAX_DIM+1),
  localparam int ACC_W   = 2*DW + $clog2(MAX_DIM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op_sel,
  input  logic [DIM_W-1:0] a_rows,
  input  logic [DIM_W-1:0] a_cols,
  input  logic [DIM_W-1:0] b_rows,
  input  logic [DIM_W-1:0] b_cols,
  input  logic [DW-1:0]    scalar_k,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic             ovf
);

  localparam int NE    = MAX_DIM * MAX_DIM;
  localparam int IDX_W = $clog2(NE);

  function automatic logic [IDX_W-1:0] fidx(input logic [DIM_W-1:0] r,
                                            input logic [DIM_W-1:0] c);
    return IDX_W'(r) * IDX_W'(MAX_DIM) + IDX_W'(c);
  endfunction

  function automatic logic dim_bad(input logic [DIM_W-1:0] d);
    return (d == '0) || (d > DIM_W'(MAX_DIM));
  endfunction

  // FSM / command state
  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [DIM_W-1:0] a_rows_q, a_rows_d, a_cols_q, a_cols_d;
  logic [DIM_W-1:0] b_rows_q, b_rows_d, b_cols_q, b_cols_d;
  logic [DIM_W-1:0] res_rows_q, res_rows_d, res_cols_q, res_cols_d;
  logic [DW-1:0]    scl_q, scl_d;
  // shared row/col walker (load, compute, output) and MAC step index
  logic [DIM_W-1:0] r_q, r_d, c_q, c_d, kidx_q, kidx_d;
  logic             fin_q, fin_d;
  logic             wr_pend_q, wr_pend_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  // registered outputs
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d, ovf_q, ovf_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DW-1:0]    out_data_q, out_data_d;

  logic [NE-1:0][DW-1:0] a_buf_q, b_buf_q, res_buf_q;

  logic             a_we, b_we;
  logic             mac_en, mac_clr, mac_ovf;
  logic [DW-1:0]    mac_a, mac_b, mac_c, mac_res;
  logic [1:0]       chk_err;
  logic [DIM_W-1:0] lim_r, lim_c, nxt_r, nxt_c;
  logic             c_end, elem_end, k_end;
  logic [IDX_W-1:0] cur_idx;

  // Command check on the latched command (valid in CHECK).
  always_comb begin
    chk_err = ERR_NONE;
    if (op_q != OP_TRANSPOSE && op_q != OP_ADD && op_q != OP_SCALAR && op_q != OP_MUL)
      chk_err = ERR_OP;
    else if (dim_bad(a_rows_q) || dim_bad(a_cols_q) ||
             (op_needs_b(op_q) && (dim_bad(b_rows_q) || dim_bad(b_cols_q))))
      chk_err = ERR_DIM;
    else if (op_q == OP_ADD && (a_rows_q != b_rows_q || a_cols_q != b_cols_q))
      chk_err = ERR_MISMATCH;
    else if (op_q == OP_MUL && a_cols_q != b_rows_q)
      chk_err = ERR_MISMATCH;
  end

  // Row-major walker limits depend on which matrix is being traversed.
  always_comb begin
    case (state_q)
      S_LOAD_A: begin lim_r = a_rows_q;   lim_c = a_cols_q;   end
      S_LOAD_B: begin lim_r = b_rows_q;   lim_c = b_cols_q;   end
      default:  begin lim_r = res_rows_q; lim_c = res_cols_q; end
    endcase
    c_end    = (c_q == lim_c - DIM_W'(1));
    elem_end = c_end && (r_q == lim_r - DIM_W'(1));
    nxt_c    = c_end ? '0 : c_q + DIM_W'(1);
    nxt_r    = c_end ? r_q + DIM_W'(1) : r_q;
    cur_idx  = fidx(r_q, c_q);
    k_end    = (op_q != OP_MUL) || (kidx_q == a_cols_q - DIM_W'(1));
  end

  // MAC operand select: every op maps onto a*b + c.
  always_comb begin
    mac_a = a_buf_q[cur_idx];
    mac_b = DW'(1);
    mac_c = '0;
    case (op_q)
      OP_TRANSPOSE: mac_a = a_buf_q[fidx(c_q, r_q)];
      OP_ADD:       mac_c = b_buf_q[cur_idx];
      OP_SCALAR:    mac_b = scl_q;
      OP_MUL: begin
        mac_a = a_buf_q[fidx(r_q, kidx_q)];
        mac_b = b_buf_q[fidx(kidx_q, c_q)];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_rows_d    = a_rows_q;
    a_cols_d    = a_cols_q;
    b_rows_d    = b_rows_q;
    b_cols_d    = b_cols_q;
    res_rows_d  = res_rows_q;
    res_cols_d  = res_cols_q;
    scl_d       = scl_q;
    r_d         = r_q;
    c_d         = c_q;
    kidx_d      = kidx_q;
    fin_d       = fin_q;
    wr_pend_d   = 1'b0;
    wr_idx_d    = wr_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    err_code_d  = err_code_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    a_we        = 1'b0;
    b_we        = 1'b0;
    mac_en      = 1'b0;
    mac_clr     = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = op_sel;
          a_rows_d   = a_rows;
          a_cols_d   = a_cols;
          b_rows_d   = b_rows;
          b_cols_d   = b_cols;
          scl_d      = scalar_k;
          busy_d     = 1'b1;
          err_code_d = ERR_NONE;
          ovf_d      = 1'b0;
          state_d    = S_CHECK;
        end
      end

      S_CHECK: begin
        if (chk_err != ERR_NONE) begin
          err_code_d = chk_err;
          error_d    = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_ERROR;
        end else begin
          in_ready_d = 1'b1;
          r_d        = '0;
          c_d        = '0;
          state_d    = S_LOAD_A;
          case (op_q)
            OP_TRANSPOSE: begin res_rows_d = a_cols_q; res_cols_d = a_rows_q; end
            OP_MUL:       begin res_rows_d = a_rows_q; res_cols_d = b_cols_q; end
            default:      begin res_rows_d = a_rows_q; res_cols_d = a_cols_q; end
          endcase
        end
      end

      S_LOAD_A, S_LOAD_B: begin
        if (in_valid && in_ready_q) begin
          a_we = (state_q == S_LOAD_A);
          b_we = (state_q == S_LOAD_B);
          r_d  = nxt_r;
          c_d  = nxt_c;
          if (elem_end) begin
            r_d = '0;
            c_d = '0;
            if (state_q == S_LOAD_A && op_needs_b(op_q)) begin
              state_d = S_LOAD_B;
            end else begin
              in_ready_d = 1'b0;
              kidx_d     = '0;
              fin_d      = 1'b0;
              state_d    = S_COMPUTE;
            end
          end
        end
      end

      // One MAC per cycle; the accumulator is registered, so each finished
      // element is written back one cycle later (wr_pend). fin_q is the extra
      // cycle that lets the last write-back land before OUTPUT reads it.
      S_COMPUTE: begin
        if (fin_q) begin
          fin_d   = 1'b0;
          state_d = S_OUTPUT;
        end else begin
          mac_en  = 1'b1;
          mac_clr = (op_q != OP_MUL) || (kidx_q == '0);
          if (!k_end) begin
            kidx_d = kidx_q + DIM_W'(1);
          end else begin
            kidx_d    = '0;
            wr_pend_d = 1'b1;
            wr_idx_d  = cur_idx;
            r_d       = nxt_r;
            c_d       = nxt_c;
            if (elem_end) begin
              r_d   = '0;
              c_d   = '0;
              fin_d = 1'b1;
            end
          end
        end
      end

      // First cycle loads element 0; afterwards each handshake loads the next
      // one in the same cycle, giving zero-gap streaming.
      S_OUTPUT: begin
        if (out_valid_q && out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_DONE;
        end else if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b1;
          out_data_d  = res_buf_q[cur_idx];
          out_last_d  = elem_end;
          r_d         = nxt_r;
          c_d         = nxt_c;
        end
      end

      S_DONE, S_ERROR: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (wr_pend_q && mac_ovf) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_rows_q    <= '0;
      a_cols_q    <= '0;
      b_rows_q    <= '0;
      b_cols_q    <= '0;
      res_rows_q  <= '0;
      res_cols_q  <= '0;
      scl_q       <= '0;
      r_q         <= '0;
      c_q         <= '0;
      kidx_q      <= '0;
      fin_q       <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_idx_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_rows_q    <= a_rows_d;
      a_cols_q    <= a_cols_d;
      b_rows_q    <= b_rows_d;
      b_cols_q    <= b_cols_d;
      res_rows_q  <= res_rows_d;
      res_cols_q  <= res_cols_d;
      scl_q       <= scl_d;
      r_q         <= r_d;
      c_q         <= c_d;
      kidx_q      <= kidx_d;
      fin_q       <= fin_d;
      wr_pend_q   <= wr_pend_d;
      wr_idx_q    <= wr_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Data buffers carry no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (a_we)      a_buf_q[cur_idx]    <= in_data;
    if (b_we)      b_buf_q[cur_idx]    <= in_data;
    if (wr_pend_q) res_buf_q[wr_idx_q] <= mac_res;
  end

  mat_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .mul_a (mac_a),
    .mul_b (mac_b),
    .add_c (mac_c),
    .res   (mac_res),
    .ovf   (mac_ovf)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mat_ops_engine.sv
// Bench for mat_ops_engine: table of command vectors with expected results,
// a result scoreboard queue, plus hand-written reset/busy sequences.
module tb_mat_ops_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] op_sel;
  logic [2:0] a_rows, a_cols, b_rows, b_cols;
  logic [7:0] scalar_k;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_last;
  logic [7:0] out_data;
  logic       busy, done, error, ovf;
  logic [1:0] err_code;

  mat_ops_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel),
    .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
    .scalar_k(scalar_k), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       op;
    logic [2:0]       ar, ac, br, bc;
    logic [7:0]       k;
    logic [5:0]       na, nb, nexp;
    logic [24:0][7:0] a, b, ex;
    logic             ovf;
    logic [1:0]       err;
  } vec_t;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] sb[$];
  vec_t       tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] narrow(input int s);
`ifdef MATOPS_SAT_EN
    return (s > 255) ? 8'd255 : 8'(s);
`else
    return 8'(s);
`endif
  endfunction

  // Reference 5x5 multiply with random operands.
  function automatic vec_t mk_mul5();
    vec_t v;
    int   s;
    v      = '0;
    v.op   = 3'b011;
    v.ar   = 3'd5; v.ac = 3'd5; v.br = 3'd5; v.bc = 3'd5;
    v.na   = 6'd25; v.nb = 6'd25; v.nexp = 6'd25;
    for (int i = 0; i < 25; i++) begin
      v.a[i] = 8'($urandom_range(0, 255));
      v.b[i] = 8'($urandom_range(0, 60));
    end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        s = 0;
        for (int k = 0; k < 5; k++) s += int'(v.a[r*5+k]) * int'(v.b[k*5+c]);
        if (s > 255) v.ovf = 1'b1;
        v.ex[r*5+c] = narrow(s);
      end
    return v;
  endfunction

  // Issue one command, stream operands, drain results against the scoreboard.
  task automatic run_vec(input string tag, input vec_t v, input bit rnd, input bit poke);
    int         cyc, beats, nin;
    bit         fin, saw_rdy, saw_err, saw_done, stalled, hs_in;
    logic [7:0] held_d, expd;
    logic       held_l;
    nin = int'(v.na) + int'(v.nb);
    for (int i = 0; i < int'(v.nexp); i++) sb.push_back(v.ex[i]);
    op_sel = v.op; a_rows = v.ar; a_cols = v.ac; b_rows = v.br; b_cols = v.bc;
    scalar_k = v.k; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_start"}, int'(busy), 1);
    cyc = 0; beats = 0; fin = 0; saw_rdy = 0; saw_err = 0; saw_done = 0;
    stalled = 0; held_d = '0; held_l = 1'b0;
    while (!fin && cyc < 3000) begin
      if (stalled) begin
        chk({tag, "_stall_valid"}, int'(out_valid), 1);
        chk({tag, "_stall_data"}, int'(out_data), int'(held_d));
        chk({tag, "_stall_last"}, int'(out_last), int'(held_l));
      end
      // a start while busy must be ignored
      if (poke && cyc == 2) begin start = 1'b1; op_sel = 3'b111; a_rows = 3'd0; end
      else start = 1'b0;
      if (in_ready) saw_rdy = 1'b1;
      in_valid = in_ready && (beats < nin) && (!rnd || $urandom_range(0, 3) != 0);
      in_data  = '0;
      if (beats < int'(v.na)) in_data = v.a[beats];
      else if (beats < nin)   in_data = v.b[beats - int'(v.na)];
      out_ready = !rnd || ($urandom_range(0, 1) == 1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk({tag, "_extra_output"}, 1, 0);
        else begin
          expd = sb.pop_front();
          chk({tag, "_out_data"}, int'(out_data), int'(expd));
          chk({tag, "_out_last"}, int'(out_last), (sb.size() == 0) ? 1 : 0);
        end
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_l  = out_last;
      hs_in   = in_valid && in_ready;
      tick();
      cyc++;
      if (hs_in) beats++;
      if (done)  begin saw_done = 1; fin = 1; end
      if (error) begin saw_err = 1;  fin = 1; end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    if (!fin) chk({tag, "_timeout"}, 0, 1);
    if (v.err != 2'd0) begin
      chk({tag, "_error_pulse"}, int'(saw_err), 1);
      chk({tag, "_err_code"}, int'(err_code), int'(v.err));
      chk({tag, "_no_in_ready"}, int'(saw_rdy), 0);
      chk({tag, "_busy_err"}, int'(busy), 0);
      tick();
      chk({tag, "_error_1cyc"}, int'(error), 0);
      chk({tag, "_err_code_held"}, int'(err_code), int'(v.err));
      sb.delete();
    end else begin
      chk({tag, "_done_pulse"}, int'(saw_done), 1);
      chk({tag, "_busy_done"}, int'(busy), 0);
      chk({tag, "_err_code0"}, int'(err_code), 0);
      chk({tag, "_sb_empty"}, sb.size(), 0);
      chk({tag, "_beats"}, beats, nin);
      chk({tag, "_ovf"}, int'(ovf), int'(v.ovf));
      tick();
      chk({tag, "_done_1cyc"}, int'(done), 0);
      sb.delete();
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_last"}, int'(out_last), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_error"}, int'(error), 0);
    chk({tag, "_err_code"}, int'(err_code), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   cyc, beats;
    bit   hs;
    vec_t v;

    // add 2x2
    tbl[0] = '0; tbl[0].op = 3'b001;
    tbl[0].ar = 3'd2; tbl[0].ac = 3'd2; tbl[0].br = 3'd2; tbl[0].bc = 3'd2;
    tbl[0].na = 6'd4; tbl[0].nb = 6'd4; tbl[0].nexp = 6'd4;
    for (int i = 0; i < 4; i++) begin
      tbl[0].a[i]  = 8'(i + 1);
      tbl[0].b[i]  = 8'(10 * (i + 1));
      tbl[0].ex[i] = 8'(11 * (i + 1));
    end
    // transpose 2x3
    tbl[1] = '0; tbl[1].op = 3'b000; tbl[1].ar = 3'd2; tbl[1].ac = 3'd3;
    tbl[1].na = 6'd6; tbl[1].nexp = 6'd6;
    for (int i = 0; i < 6; i++) tbl[1].a[i] = 8'(i + 1);
    tbl[1].ex[0] = 8'd1; tbl[1].ex[1] = 8'd4; tbl[1].ex[2] = 8'd2;
    tbl[1].ex[3] = 8'd5; tbl[1].ex[4] = 8'd3; tbl[1].ex[5] = 8'd6;
    // multiply 2x3 * 3x2
    tbl[2] = '0; tbl[2].op = 3'b011;
    tbl[2].ar = 3'd2; tbl[2].ac = 3'd3; tbl[2].br = 3'd3; tbl[2].bc = 3'd2;
    tbl[2].na = 6'd6; tbl[2].nb = 6'd6; tbl[2].nexp = 6'd4;
    for (int i = 0; i < 6; i++) begin
      tbl[2].a[i] = 8'(i + 1);
      tbl[2].b[i] = 8'(i + 7);
    end
    tbl[2].ex[0] = 8'd58; tbl[2].ex[1] = 8'd64; tbl[2].ex[2] = 8'd139; tbl[2].ex[3] = 8'd154;
    // scalar k=100 on [3] -> 300 overflows
    tbl[3] = '0; tbl[3].op = 3'b010; tbl[3].ar = 3'd1; tbl[3].ac = 3'd1; tbl[3].k = 8'd100;
    tbl[3].na = 6'd1; tbl[3].nexp = 6'd1; tbl[3].a[0] = 8'd3; tbl[3].ovf = 1'b1;
`ifdef MATOPS_SAT_EN
    tbl[3].ex[0] = 8'd255;
`else
    tbl[3].ex[0] = 8'd44;
`endif
    // multiply inner-dim mismatch
    tbl[4] = '0; tbl[4].op = 3'b011;
    tbl[4].ar = 3'd2; tbl[4].ac = 3'd3; tbl[4].br = 3'd2; tbl[4].bc = 3'd2; tbl[4].err = 2'd2;
    // illegal op, even with bad dims
    tbl[5] = '0; tbl[5].op = 3'b111; tbl[5].ar = 3'd0; tbl[5].ac = 3'd2; tbl[5].err = 2'd3;
    // zero rows
    tbl[6] = '0; tbl[6].op = 3'b000; tbl[6].ar = 3'd0; tbl[6].ac = 3'd2; tbl[6].err = 2'd1;
    // rows above MAX_DIM
    tbl[7] = '0; tbl[7].op = 3'b001;
    tbl[7].ar = 3'd6; tbl[7].ac = 3'd1; tbl[7].br = 3'd6; tbl[7].bc = 3'd1; tbl[7].err = 2'd1;

    rst_n = 1'b0; start = 1'b0; op_sel = '0; a_rows = '0; a_cols = '0;
    b_rows = '0; b_cols = '0; scalar_k = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    chk_reset_outs("reset");
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 8; t++) run_vec($sformatf("vec%0d", t), tbl[t], 1'b0, 1'b0);

    // start while busy must not disturb the running add
    run_vec("busy_start", tbl[0], 1'b0, 1'b1);

    // 5x5 multiply with random back-pressure and input gaps
    v = mk_mul5();
    run_vec("mul5_rnd", v, 1'b1, 1'b0);

    // reset asserted while results are pending in OUTPUT
    op_sel = 3'b001; a_rows = 3'd2; a_cols = 3'd2; b_rows = 3'd2; b_cols = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    cyc = 0; beats = 0;
    while (!out_valid && cyc < 200) begin
      in_valid = in_ready && beats < 8;
      in_data  = (beats < 4) ? tbl[0].a[beats] : tbl[0].b[(beats >= 4) ? beats - 4 : 0];
      hs = in_valid && in_ready;
      tick();
      cyc++;
      if (hs) beats++;
    end
    in_valid = 1'b0;
    chk("rst_mid_reached_output", int'(out_valid), 1);
    chk("rst_mid_first_data", int'(out_data), 11);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("rst_mid_no_partial", int'(out_valid), 0);
    chk("rst_mid_idle_busy", int'(busy), 0);

    run_vec("after_rst", tbl[0], 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
